// File: rtl/gpio_motor_pwm_multi.sv
// rtl/gpio_motor_pwm_multi.sv - multi-channel burst PWM generator for servo/motor headers
// Optional sticky done flags and irq output are built when MOTOR_DONE_IRQ_EN is defined.
module gpio_motor_pwm_multi #(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned PERIOD    = 20'hA1220,
  parameter int unsigned DEF_LOOPS = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CH_NUM-1:0] ctrl_we,
  input  logic [31:0]       ctrl_wdata,
  output logic [CH_NUM-1:0] ack,
  output logic [CH_NUM-1:0] busy,
`ifdef MOTOR_DONE_IRQ_EN
  output logic [CH_NUM-1:0] done,
  output logic              irq,
`endif
  output logic [CH_NUM-1:0] pin
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
  localparam logic [7:0]       DEF_L8    = 8'(DEF_LOOPS);

  logic             w_start, w_cont, w_stop;
  logic [7:0]       w_loops;
  logic [CNT_W-1:0] w_high;
  logic             unused_wdata;

  assign w_start      = ctrl_wdata[31];
  assign w_cont       = ctrl_wdata[30];
  assign w_stop       = ctrl_wdata[29];
  assign w_loops      = (ctrl_wdata[27:20] == 8'd0) ? DEF_L8 : ctrl_wdata[27:20];
  assign w_high       = ctrl_wdata[CNT_W-1:0];
  assign unused_wdata = ^ctrl_wdata;

  state_e           state_q     [CH_NUM];
  state_e           state_d     [CH_NUM];
  logic [CNT_W-1:0] cnt_q       [CH_NUM];
  logic [CNT_W-1:0] cnt_d       [CH_NUM];
  logic [CNT_W-1:0] high_q      [CH_NUM];
  logic [CNT_W-1:0] high_d      [CH_NUM];
  logic [7:0]       loops_q     [CH_NUM];
  logic [7:0]       loops_d     [CH_NUM];
  logic [CNT_W-1:0] shd_high_q  [CH_NUM];
  logic [CNT_W-1:0] shd_high_d  [CH_NUM];
  logic [7:0]       shd_loops_q [CH_NUM];
  logic [7:0]       shd_loops_d [CH_NUM];
  logic [CH_NUM-1:0] cont_q, cont_d;
  logic [CH_NUM-1:0] shd_cont_q, shd_cont_d;
  logic [CH_NUM-1:0] shd_vld_q, shd_vld_d;
  logic [CH_NUM-1:0] ack_q, ack_d;
`ifdef MOTOR_DONE_IRQ_EN
  logic [CH_NUM-1:0] done_q, done_d;
  logic              irq_q, irq_d;
`endif

  always_comb begin
    logic we_c, pe_c, shd_use_c;
    we_c        = 1'b0;
    pe_c        = 1'b0;
    shd_use_c   = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    high_d      = high_q;
    loops_d     = loops_q;
    shd_high_d  = shd_high_q;
    shd_loops_d = shd_loops_q;
    cont_d      = cont_q;
    shd_cont_d  = shd_cont_q;
    shd_vld_d   = shd_vld_q;
    ack_d       = ctrl_we;
`ifdef MOTOR_DONE_IRQ_EN
    done_d      = done_q;
`endif
    for (int c = 0; c < CH_NUM; c++) begin
      we_c      = ctrl_we[c];
      pe_c      = (state_q[c] == S_RUN) && (cnt_q[c] == PERIOD_M1);
      // a plain (no start, no stop) write cancels a pending shadow even at the boundary
      shd_use_c = shd_vld_q[c] && !(we_c && !w_start && !w_stop);

      if (state_q[c] == S_RUN) begin
        cnt_d[c] = pe_c ? '0 : cnt_q[c] + CNT_W'(1);
      end

      if (pe_c) begin
        if (shd_use_c) begin
          high_d[c]    = shd_high_q[c];
          loops_d[c]   = shd_loops_q[c];
          cont_d[c]    = shd_cont_q[c];
          shd_vld_d[c] = 1'b0;
        end else if (!cont_q[c] && loops_q[c] == 8'd1) begin
          state_d[c] = S_IDLE;
`ifdef MOTOR_DONE_IRQ_EN
          done_d[c]  = 1'b1;
`endif
        end else if (!cont_q[c]) begin
          loops_d[c] = loops_q[c] - 8'd1;
        end
      end

      if (we_c) begin
`ifdef MOTOR_DONE_IRQ_EN
        done_d[c] = 1'b0;
`endif
        if (w_stop) begin
          state_d[c]   = S_IDLE;
          cnt_d[c]     = '0;
          shd_vld_d[c] = 1'b0;
        end else if (w_start) begin
          // at a period boundary the new word takes effect directly, as a shadow would
          if (state_q[c] == S_IDLE || pe_c) begin
            state_d[c]   = S_RUN;
            cnt_d[c]     = '0;
            high_d[c]    = w_high;
            loops_d[c]   = w_loops;
            cont_d[c]    = w_cont;
            shd_vld_d[c] = 1'b0;
          end else begin
            shd_high_d[c]  = w_high;
            shd_loops_d[c] = w_loops;
            shd_cont_d[c]  = w_cont;
            shd_vld_d[c]   = 1'b1;
          end
        end else begin
          shd_vld_d[c] = 1'b0;
        end
      end
    end
`ifdef MOTOR_DONE_IRQ_EN
    irq_d = |done_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int c = 0; c < CH_NUM; c++) begin
        state_q[c]     <= S_IDLE;
        cnt_q[c]       <= '0;
        high_q[c]      <= '0;
        loops_q[c]     <= '0;
        shd_high_q[c]  <= '0;
        shd_loops_q[c] <= '0;
      end
      cont_q     <= '0;
      shd_cont_q <= '0;
      shd_vld_q  <= '0;
      ack_q      <= '0;
`ifdef MOTOR_DONE_IRQ_EN
      done_q     <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_q      <= high_d;
      loops_q     <= loops_d;
      shd_high_q  <= shd_high_d;
      shd_loops_q <= shd_loops_d;
      cont_q      <= cont_d;
      shd_cont_q  <= shd_cont_d;
      shd_vld_q   <= shd_vld_d;
      ack_q       <= ack_d;
`ifdef MOTOR_DONE_IRQ_EN
      done_q      <= done_d;
      irq_q       <= irq_d;
`endif
    end
  end

  // pin is decoded from registers so pulse width and period are exact
  always_comb begin
    busy = '0;
    pin  = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      busy[c] = (state_q[c] == S_RUN);
      pin[c]  = (state_q[c] == S_RUN) && (cnt_q[c] < high_q[c]);
    end
  end

  assign ack = ack_q;
`ifdef MOTOR_DONE_IRQ_EN
  assign done = done_q;
  assign irq  = irq_q;
`endif

endmodule
